// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Wait-stated byte/halfword/word data-memory responder for the
//            load/store handshake, backed by a word-organised internal RAM.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_Mem_rd,
    input  logic        io_Mem_wr_valid,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic [2:0]  io_funct3,
    output logic [31:0] io_rdata,
    output logic        io_DataMem_rdy,
    output logic        io_misalign
);
    localparam int         c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rd;
    logic                  r_wr;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic [3:0]            r_cnt;
    logic                  r_rdy;
    logic [31:0]           r_rdata;
    logic                  r_misalign;
    logic [31:0]           r_mem [c_DEPTH];

    logic                  w_idle;
    logic                  w_req;
    logic                  w_sel_rd;
    logic                  w_sel_wr;
    logic [ADDR_WIDTH+1:0] w_sel_addr;
    logic [31:0]           w_sel_wdata;
    logic [2:0]            w_sel_funct3;
    logic [1:0]            w_lane;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;
    logic                  w_mis;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_rep;
    logic                  w_rdy_nxt;
    logic [31:0]           w_rdata_nxt;
    logic                  w_mis_nxt;
    logic                  w_unused_addr;

    assign w_unused_addr = ^io_addr[31:ADDR_WIDTH+2];

    // With zero wait states the response is formed at the accepting edge, so
    // the live inputs are used in IDLE and the captured copies otherwise.
    assign w_idle       = (r_state == S_IDLE);
    assign w_req        = io_Mem_rd | io_Mem_wr_valid;
    assign w_sel_rd     = w_idle ? io_Mem_rd                  : r_rd;
    assign w_sel_wr     = w_idle ? io_Mem_wr_valid            : r_wr;
    assign w_sel_addr   = w_idle ? io_addr[ADDR_WIDTH+1:0]    : r_addr;
    assign w_sel_wdata  = w_idle ? io_wdata                   : r_wdata;
    assign w_sel_funct3 = w_idle ? io_funct3                  : r_funct3;

    assign w_lane = w_sel_addr[1:0];
    assign w_word = r_mem[w_sel_addr[ADDR_WIDTH+1:2]];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = 32'd0;
        w_mis       = 1'b1;
        w_be        = 4'b0000;
        w_wdata_rep = w_sel_wdata;
        case (w_sel_funct3)
            3'b000: begin w_load_data = {{24{w_byte[7]}}, w_byte};  w_mis = 1'b0;      end
            3'b100: begin w_load_data = {24'd0, w_byte};            w_mis = 1'b0;      end
            3'b001: begin w_load_data = {{16{w_half[15]}}, w_half}; w_mis = w_lane[0]; end
            3'b101: begin w_load_data = {16'd0, w_half};            w_mis = w_lane[0]; end
            3'b010: begin w_load_data = w_word;                     w_mis = |w_lane;   end
            default: begin w_load_data = 32'd0;                     w_mis = 1'b1;      end
        endcase
        case (w_sel_funct3[1:0])
            2'b00: begin w_be = 4'b0001 << w_lane;                 w_wdata_rep = {4{w_sel_wdata[7:0]}};  end
            2'b01: begin w_be = w_lane[1] ? 4'b1100 : 4'b0011;     w_wdata_rep = {2{w_sel_wdata[15:0]}}; end
            2'b10: begin w_be = 4'b1111;                           w_wdata_rep = w_sel_wdata;            end
            default: begin w_be = 4'b0000;                         w_wdata_rep = w_sel_wdata;            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rdy_nxt   = 1'b0;
        w_rdata_nxt = 32'd0;
        w_mis_nxt   = 1'b0;
        case (r_state)
            S_IDLE: if (w_req) w_state_nxt = (c_WAIT == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!w_req)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == 4'd1)
                    w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_RESP) begin
            w_rdy_nxt = 1'b1;
            w_mis_nxt = w_mis;
            if (w_sel_rd && !w_sel_wr && !w_mis)
                w_rdata_nxt = w_load_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_funct3   <= 3'd0;
            r_cnt      <= 4'd0;
            r_rdy      <= 1'b0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            if (w_idle && w_req) begin
                r_rd     <= io_Mem_rd;
                r_wr     <= io_Mem_wr_valid;
                r_addr   <= io_addr[ADDR_WIDTH+1:0];
                r_wdata  <= io_wdata;
                r_funct3 <= io_funct3;
                r_cnt    <= c_WAIT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_rdy      <= w_rdy_nxt;
            r_rdata    <= w_rdata_nxt;
            r_misalign <= w_mis_nxt;
        end
    end

    // Stores commit on the edge that leaves RESP; RAM has no reset.
    always_ff @(posedge clock) begin
        if (r_state == S_RESP && r_wr && !w_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[r_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

    assign io_DataMem_rdy = r_rdy;
    assign io_rdata       = r_rdata;
    assign io_misalign    = r_misalign;

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder on the far end of the control path's load/store handshake. The decoder raises `io_Mem_rd` or `io_Mem_wr_valid` and holds it. This block accepts the request, inserts a configurable number of wait states, then performs a byte, halfword or word access on an internal word-organised RAM. It completes the access by pulsing `io_DataMem_rdy` for one cycle. It sits between the datapath's ALU address/store-data outputs and the writeback mux, and stands in for external data memory in simulation and on small targets.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states between request acceptance and `io_DataMem_rdy`; legal range 0–15.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `io_Mem_rd` input 1: load request, held until `io_DataMem_rdy`.
- `io_Mem_wr_valid` input 1: store request, held until `io_DataMem_rdy`.
- `io_addr` input 32: byte address (ALU result).
- `io_wdata` input 32: store data (rs2).
- `io_funct3` input 3: IR[14:12]; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `io_rdata` output 32: extended load data; valid only in the `io_DataMem_rdy` cycle.
- `io_DataMem_rdy` output 1: one-cycle completion pulse.
- `io_misalign` output 1: access faulted; valid only in the `io_DataMem_rdy` cycle.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - A request (rd or wr high) at a clock edge is accepted.
  - On acceptance, `io_addr`, `io_wdata`, `io_funct3` and the op are captured into registers, and the counter is loaded with WAIT_CYCLES.
  - Next state is WAIT, or RESP if WAIT_CYCLES = 0.
- **WAIT:**
  - The counter decrements each cycle; at 1 the next state is RESP.
  - If both request inputs drop, the access aborts: the state returns to IDLE, no RAM write occurs and no rdy is issued.
- **RESP (registered outputs):**
  - `io_DataMem_rdy` = 1.
  - A store is committed to RAM at this edge.
  - `io_rdata` and `io_misalign` are driven.
  - Next state is IDLE.
- **Op priority:** if rd and wr are both high at acceptance, the access is a store and `io_rdata` = 0.
- **Addressing:**
  - Word index = addr[ADDR_WIDTH+1:2]; higher bits are ignored (modulo wrap).
  - Lane = addr[1:0].
- **Loads:**
  - B/BU select the byte at lane×8; H/HU select the halfword at addr[1]×16.
  - B/H are sign-extended; BU/HU are zero-extended. W returns the whole word.
- **Stores:**
  - SB writes only lane byte (wdata[7:0]); SH writes only the addressed halfword (wdata[15:0]); SW writes all 4 bytes.
  - Other bytes are untouched.
- **Misalignment:**
  - H/HU/SH fault when addr[0] = 1; W/SW fault when addr[1:0] ≠ 00.
  - On a fault: RAM is not modified, `io_rdata` = 0, `io_misalign` = 1, rdy still pulses.
- **Illegal funct3:** 011, 110 and 111 behave as misaligned.
- **Reset:** RAM contents are not cleared by reset.

## Timing
- **Reset values:** `io_DataMem_rdy` = 0, `io_rdata` = 0, `io_misalign` = 0, state IDLE, counter 0, captured registers 0.
- **Reset mid-access:** an asserted `reset` forces IDLE immediately and suppresses any pending store.
- **Latency:**
  - Request first seen high at edge N → rdy high in cycle N+WAIT_CYCLES+1.
  - WAIT_CYCLES = 0 gives rdy the cycle after acceptance.
- **rdy pulse:** high exactly one cycle per accepted, unaborted request.
- **Outputs outside the rdy cycle:** `io_rdata` and `io_misalign` return to 0 the cycle after rdy.
- **Back-to-back:** a request still high in the cycle after rdy is a new transaction accepted at that edge (IDLE). A held store is therefore rewritten, and a held load is re-read.
- **Input stability:** input changes after acceptance are ignored; only the captured values are used.
- **Read-after-write:** a load accepted the cycle after a store's rdy returns the new data.

## Test plan
- **SW then LW:** with WAIT_CYCLES=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → each rdy lands 3 cycles after the request; `io_rdata` = 0xDEADBEEF, misalign = 0.
- **Byte/halfword extension:** on word 0x80FF7F01 at 0x20: LB 0x21 → 0x0000007F; LB 0x23 → 0xFFFFFF80; LBU 0x22 → 0x000000FF; LH 0x22 → 0xFFFF80FF; LHU 0x20 → 0x00007F01.
- **Partial stores:** SB 0x25 wdata 0x000000AA onto word 0x11223344 → LW 0x24 returns 0x1122AA44; SH 0x26 wdata 0xBEEF → LW returns 0xBEEFAA44.
- **Misaligned:** LW 0x31 and SH 0x33 → rdy pulses with misalign = 1 and rdata = 0; LW 0x30 afterwards shows prior contents unchanged.
- **Abort and reset:** drop `io_Mem_wr_valid` after 1 wait cycle → no rdy and memory unchanged. Assert `reset` low during WAIT → outputs 0, no write, and the next request completes normally.
- **Zero wait, held request:** WAIT_CYCLES=0 with `io_Mem_rd` held 4 cycles → rdy is high on alternate cycles (2 pulses), and both pulses return identical data.
